clock_divider_n_m: RTL and testbench



---
 rtl/clock_divider_n_m.sv | 186 ++++++++++++++++++
 tb/tb_clock_divider_n_m.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_divider_n_m.sv
// Run-time programmable clock divider: clkout = clkin / (div+1), retuned glitch-free through a req/ack handshake.
// Optional build macro CLKDIV_ODD_5050_EN adds a negedge flop that gives exact 50% duty for odd divisors.

module clock_divider_n_m #(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned RESET_DIV = 2,
  parameter bit          RESET_INV = 1'b0
) (
  input  logic             clkin,
  input  logic             reset,
  input  logic [WIDTH-1:0] div,
  input  logic             invert_in,
  input  logic             div_req,
  output logic             busy,
  output logic             div_ack,
  output logic             period_start,
  output logic             clkout
);

  localparam logic [WIDTH-1:0] RST_DIV_FIELD = WIDTH'(RESET_DIV - 1);
  localparam logic             RST_BYP       = (RESET_DIV == 1);
  localparam logic             RST_INV       = RST_BYP ? 1'b0 : RESET_INV;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_PEND   = 2'd1,
    S_SWITCH = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_div;
  logic             r_inv;
  logic             r_en;
  logic             r_byp_tgt;
  logic             r_byp;
  logic             r_run;
  logic [WIDTH-1:0] r_cnt;
  logic             r_clk_div;
  logic             r_period_start;
  logic             r_busy;
  logic             r_div_ack;
  logic [WIDTH-1:0] r_pend_div;
  logic             r_pend_inv;

  logic [WIDTH:0]   w_n;
  logic [WIDTH-1:0] w_half;
  logic             w_wrap;
  logic [WIDTH-1:0] w_cnt_nxt;
  logic             w_raw;
  logic             w_div_out;

  // N = r_div+1 is WIDTH+1 bits wide so that 2^WIDTH is representable
  assign w_n       = {1'b0, r_div} + (WIDTH+1)'(1);
  assign w_half    = WIDTH'(w_n >> 1);
  assign w_wrap    = (r_cnt == r_div);
  assign w_cnt_nxt = w_wrap ? '0 : r_cnt + WIDTH'(1);
  assign w_raw     = r_clk_div ^ r_inv;

  // Divided-clock engine plus request FSM; FSM overrides the engine on switch edges
  always_ff @(posedge clkin or posedge reset) begin : p_main
    if (reset) begin
      r_state        <= S_IDLE;
      r_div          <= RST_DIV_FIELD;
      r_inv          <= RST_INV;
      r_en           <= ~RST_BYP;
      r_byp_tgt      <= RST_BYP;
      r_run          <= 1'b0;
      r_cnt          <= '0;
      r_clk_div      <= RST_INV;
      r_period_start <= 1'b0;
      r_busy         <= 1'b0;
      r_div_ack      <= 1'b0;
      r_pend_div     <= '0;
      r_pend_inv     <= 1'b0;
    end else begin
      r_run     <= 1'b1;
      r_div_ack <= 1'b0;

      if (r_run) begin
        if (r_en && (r_state != S_SWITCH)) begin
          r_cnt          <= w_cnt_nxt;
          r_clk_div      <= (r_cnt < w_half) ^ r_inv;
          r_period_start <= (r_cnt == '0);
        end else begin
          r_cnt          <= '0;
          r_clk_div      <= 1'b0;
          r_period_start <= 1'b0;
        end
      end

      case (r_state)
        S_IDLE: begin
          if (div_req) begin
            r_pend_div <= div;
            r_pend_inv <= invert_in;
            r_busy     <= 1'b1;
            r_state    <= S_PEND;
          end
        end

        S_PEND: begin
          if (r_en) begin
            if (w_wrap) begin
              if (r_pend_div != '0) begin
                r_div     <= r_pend_div;
                r_inv     <= r_pend_inv;
                r_busy    <= 1'b0;
                r_div_ack <= 1'b1;
                r_state   <= S_IDLE;
              end else begin
                // Park the divided clock low so the negedge mux swap sees two low inputs
                r_clk_div <= 1'b0;
                r_inv     <= 1'b0;
                r_byp_tgt <= 1'b1;
                r_state   <= S_SWITCH;
              end
            end
          end else if (r_pend_div == '0) begin
            r_busy    <= 1'b0;
            r_div_ack <= 1'b1;
            r_state   <= S_IDLE;
          end else begin
            r_div     <= r_pend_div;
            r_byp_tgt <= 1'b0;
            r_state   <= S_SWITCH;
          end
        end

        S_SWITCH: begin
          if (r_byp == r_byp_tgt) begin
            r_busy    <= 1'b0;
            r_div_ack <= 1'b1;
            r_state   <= S_IDLE;
            if (r_byp_tgt) begin
              r_en  <= 1'b0;
              r_div <= '0;
            end else begin
              // First divided period starts on this edge: cnt 0 is consumed now
              r_en           <= 1'b1;
              r_inv          <= r_pend_inv;
              r_cnt          <= WIDTH'(1);
              r_clk_div      <= ~r_pend_inv;
              r_period_start <= 1'b1;
            end
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Bypass select moves only while clkin is low and the divided phase is low
  always_ff @(negedge clkin or posedge reset) begin : p_byp
    if (reset) begin
      r_byp <= RST_BYP;
    end else if (!w_raw) begin
      r_byp <= r_byp_tgt;
    end
  end

`ifdef CLKDIV_ODD_5050_EN
  logic r_raw_neg;
  logic w_odd;

  // Half-cycle delayed copy of the raw phase stretches the high time to N/2
  always_ff @(negedge clkin or posedge reset) begin : p_raw_neg
    if (reset) begin
      r_raw_neg <= 1'b0;
    end else begin
      r_raw_neg <= w_raw;
    end
  end

  assign w_odd     = r_en && !r_div[0] && (r_div != '0);
  assign w_div_out = w_odd ? ((w_raw | r_raw_neg) ^ r_inv) : r_clk_div;
`else
  assign w_div_out = r_clk_div;
`endif

  assign clkout       = r_byp ? (clkin & ~reset) : w_div_out;
  assign busy         = r_busy;
  assign div_ack      = r_div_ack;
  assign period_start = r_period_start;

endmodule

// File: tb/tb_clock_divider_n_m.sv
// Directed bench for clock_divider_n_m: scoreboarded per-half-cycle clkout/period_start checks plus handshake checks.

module tb_clock_divider_n_m;

  localparam int unsigned W = 4;

  logic         clkin;
  logic         reset;
  logic [W-1:0] div;
  logic         invert_in;
  logic         div_req;
  logic         busy;
  logic         div_ack;
  logic         period_start;
  logic         clkout;

  int           checks;
  int           errors;
  int           ack_cnt;
  int           a0;
  int           k;
  bit           mon_en;
  time          t_last;
  logic [2:0]   sb[$];

  clock_divider_n_m #(
    .WIDTH     (W),
    .RESET_DIV (2),
    .RESET_INV (1'b0)
  ) dut (
    .clkin        (clkin),
    .reset        (reset),
    .div          (div),
    .invert_in    (invert_in),
    .div_req      (div_req),
    .busy         (busy),
    .div_ack      (div_ack),
    .period_start (period_start),
    .clkout       (clkout)
  );

  initial begin
    clkin = 1'b0;
    forever #5 clkin = ~clkin;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  always @(negedge clkin) begin
    if (div_ack === 1'b1) ack_cnt = ack_cnt + 1;
  end

  // Any clkout level must last at least one clkin phase (5 time units)
  always @(clkout) begin
    if (mon_en) begin
      checks = checks + 1;
      assert (($time - t_last) >= 5) else begin
        errors = errors + 1;
        $error("FAIL runt_pulse observed=%0t expected>=5", $time - t_last);
      end
    end
    t_last = $time;
  end

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      errors = errors + 1;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic checkn(input string tag, input int obs, input int exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      errors = errors + 1;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Expected {period_start, clkout high half, clkout low half} for cycle c of a period of n
  function automatic logic [2:0] exp_cycle(input int n, input bit inv, input int c);
    logic raw;
    logic h;
`ifdef CLKDIV_ODD_5050_EN
    logic rawp;
`endif
    if (n == 1) return 3'b010;
    raw = (c < n / 2);
    h   = raw;
`ifdef CLKDIV_ODD_5050_EN
    rawp = (((c + n - 1) % n) < n / 2);
    if ((n % 2) == 1) h = raw | rawp;
`endif
    return {(c == 0), h ^ inv, raw ^ inv};
  endfunction

  // Next posedge begins cycle c0 of a period of n
  task automatic check_run(input int n, input bit inv, input int c0, input int cycles, input string tag);
    logic [2:0] e;
    for (int i = 0; i < cycles; i++) sb.push_back(exp_cycle(n, inv, (c0 + i) % n));
    while (sb.size() != 0) begin
      e = sb.pop_front();
      @(posedge clkin); #2;
      check1({tag, "_ps"}, period_start, e[2]);
      check1({tag, "_hi_half"}, clkout, e[1]);
      @(negedge clkin); #2;
      check1({tag, "_lo_half"}, clkout, e[0]);
    end
  endtask

  task automatic request(input logic [W-1:0] d, input logic inv, input string tag);
    div       = d;
    invert_in = inv;
    div_req   = 1'b1;
    @(posedge clkin); #2;
    div_req = 1'b0;
    check1({tag, "_busy_rise"}, busy, 1'b1);
  endtask

  task automatic wait_ack(input int bound, input string tag);
    int n;
    n = 0;
    while (n < bound && div_ack !== 1'b1) begin
      @(posedge clkin); #2;
      n++;
    end
    check1({tag, "_ack"}, div_ack, 1'b1);
    check1({tag, "_busy_fall"}, busy, 1'b0);
  endtask

  task automatic wait_ps(input int bound, input string tag);
    int n;
    n = 0;
    do begin
      @(posedge clkin); #2;
      n++;
    end while (period_start !== 1'b1 && n < bound);
    check1({tag, "_sync_ps"}, period_start, 1'b1);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    ack_cnt   = 0;
    mon_en    = 1'b0;
    t_last    = 0;
    reset     = 1'b1;
    div       = '0;
    invert_in = 1'b0;
    div_req   = 1'b0;

    // Reset values
    repeat (3) @(negedge clkin);
    #2;
    check1("rst_busy", busy, 1'b0);
    check1("rst_ack", div_ack, 1'b0);
    check1("rst_ps", period_start, 1'b0);
    check1("rst_clkout", clkout, 1'b0);

    // Release: first period starts on the 2nd posedge
    @(negedge clkin); #1;
    reset  = 1'b0;
    mon_en = 1'b1;
    @(posedge clkin); #2;
    check1("first_edge_ps", period_start, 1'b0);
    check1("first_edge_clkout", clkout, 1'b0);
    check_run(2, 1'b0, 0, 8, "reset_n2");
    check1("reset_n2_busy", busy, 1'b0);

    // N=2 -> N=5
    request(W'(4), 1'b0, "n5");
    wait_ack(2, "n5");
    check_run(5, 1'b0, 0, 15, "n5");

    // N=5 -> N=3 -> bypass -> N=8
    request(W'(2), 1'b0, "n3");
    wait_ack(5, "n3");
    check_run(3, 1'b0, 0, 9, "n3");
    request(W'(0), 1'b0, "byp");
    wait_ack(4, "byp");
    check_run(1, 1'b0, 0, 6, "byp");
    request(W'(7), 1'b0, "n8");
    wait_ack(2, "n8");
    wait_ps(10, "n8");
    check_run(8, 1'b0, 1, 15, "n8");

    // Requests held every cycle while pending: only the first (N=4) is taken
    a0        = ack_cnt;
    div       = W'(3);
    invert_in = 1'b0;
    div_req   = 1'b1;
    @(posedge clkin); #2;
    check1("spam_busy_rise", busy, 1'b1);
    div       = W'(1);
    invert_in = 1'b1;
    k = 0;
    while (k < 8 && div_ack !== 1'b1) begin
      @(posedge clkin); #2;
      k++;
    end
    div_req = 1'b0;
    check1("spam_ack", div_ack, 1'b1);
    check_run(4, 1'b0, 0, 12, "spam_n4");
    checkn("spam_ack_count", ack_cnt - a0, 1);

    // Inverted N=4
    request(W'(3), 1'b1, "inv4");
    wait_ack(4, "inv4");
    check_run(4, 1'b1, 0, 12, "inv4");

    // Reset while a request is pending
    a0 = ack_cnt;
    request(W'(9), 1'b0, "rstpend");
    mon_en = 1'b0;
    reset  = 1'b1;
    #1;
    check1("rstpend_busy", busy, 1'b0);
    check1("rstpend_ack", div_ack, 1'b0);
    check1("rstpend_ps", period_start, 1'b0);
    check1("rstpend_clkout", clkout, 1'b0);
    repeat (3) begin
      @(posedge clkin); #2;
      check1("rstpend_hold_ack", div_ack, 1'b0);
      check1("rstpend_hold_busy", busy, 1'b0);
    end
    @(negedge clkin); #1;
    reset = 1'b0;
    @(posedge clkin); #2;
    check1("resume_first_ps", period_start, 1'b0);
    check1("resume_first_clkout", clkout, 1'b0);
    check_run(2, 1'b0, 0, 8, "resume_n2");
    checkn("rstpend_no_ack", ack_cnt - a0, 0);
    mon_en = 1'b1;

    // Largest divisor, div all ones
    request(W'(15), 1'b0, "n16");
    wait_ack(2, "n16");
    check_run(16, 1'b0, 0, 32, "n16");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
